// File: rtl/vx_sched_state_mon_if.sv
// Event, observation and expected-state bundle for the warp scheduler state monitor.
// The master side is whatever drives scheduler events; the slave side is the monitor.
interface vx_sched_state_mon_if #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_BR_CH   = 2,
    parameter int IPDOM_DEPTH = 4,
    parameter int PC_BITS     = 30
);
    localparam int WID_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DEPTH_W = $clog2(IPDOM_DEPTH + 1);

    logic                                   wspawn_valid;
    logic [NUM_WARPS-1:0]                   wspawn_mask;
    logic [PC_BITS-1:0]                     wspawn_pc;
    logic                                   tmc_valid;
    logic [WID_W-1:0]                       tmc_wid;
    logic [NUM_THREADS-1:0]                 tmc_mask;
    logic                                   split_valid;
    logic [WID_W-1:0]                       split_wid;
    logic [NUM_THREADS-1:0]                 split_then_mask;
    logic [NUM_THREADS-1:0]                 split_else_mask;
    logic [PC_BITS-1:0]                     split_else_pc;
    logic                                   join_valid;
    logic [WID_W-1:0]                       join_wid;
    logic [NUM_BR_CH-1:0]                   br_valid;
    logic [NUM_BR_CH-1:0]                   br_taken;
    logic [NUM_BR_CH-1:0][WID_W-1:0]        br_wid;
    logic [NUM_BR_CH-1:0][PC_BITS-1:0]      br_target;
    logic                                   check_en;
    logic [NUM_WARPS-1:0]                   obs_active_warps;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0]  obs_thread_masks;
    logic [NUM_WARPS-1:0]                   exp_active_warps;
    logic [NUM_WARPS-1:0][NUM_THREADS-1:0]  exp_thread_masks;
    logic [NUM_WARPS-1:0][PC_BITS-1:0]      exp_warp_pcs;
    logic [NUM_WARPS-1:0][DEPTH_W-1:0]      ipdom_depth;
    logic                                   err_valid;
    logic [2:0]                             err_code;
    logic [WID_W-1:0]                       err_wid;
    logic [15:0]                            err_count;

    modport master (
        output wspawn_valid, wspawn_mask, wspawn_pc,
        output tmc_valid, tmc_wid, tmc_mask,
        output split_valid, split_wid, split_then_mask, split_else_mask, split_else_pc,
        output join_valid, join_wid,
        output br_valid, br_taken, br_wid, br_target,
        output check_en, obs_active_warps, obs_thread_masks,
        input  exp_active_warps, exp_thread_masks, exp_warp_pcs, ipdom_depth,
        input  err_valid, err_code, err_wid, err_count
    );

    modport slave (
        input  wspawn_valid, wspawn_mask, wspawn_pc,
        input  tmc_valid, tmc_wid, tmc_mask,
        input  split_valid, split_wid, split_then_mask, split_else_mask, split_else_pc,
        input  join_valid, join_wid,
        input  br_valid, br_taken, br_wid, br_target,
        input  check_en, obs_active_warps, obs_thread_masks,
        output exp_active_warps, exp_thread_masks, exp_warp_pcs, ipdom_depth,
        output err_valid, err_code, err_wid, err_count
    );
endinterface

// File: rtl/vx_sched_state_mon.sv
// Reference model of warp scheduler state (active set, thread masks, PCs, IPDOM stacks)
// that flags illegal events and disagreement with the observed scheduler state.
module vx_sched_state_mon #(
    parameter int                 NUM_WARPS   = 4,
    parameter int                 NUM_THREADS = 4,
    parameter int                 NUM_BR_CH   = 2,
    parameter int                 IPDOM_DEPTH = 4,
    parameter int                 PC_BITS     = 30,
    parameter logic [PC_BITS-1:0] STARTUP_PC  = '0
) (
    input logic               clk,
    input logic               reset,
    vx_sched_state_mon_if.slave bus
);
    localparam int WID_W   = (NUM_WARPS > 1) ? $clog2(NUM_WARPS) : 1;
    localparam int DEPTH_W = $clog2(IPDOM_DEPTH + 1);

    typedef logic [NUM_THREADS-1:0] mask_t;
    typedef logic [PC_BITS-1:0]     pc_t;
    typedef logic [DEPTH_W-1:0]     sp_t;

    logic [NUM_WARPS-1:0] w_vecAct, w_vecMask, w_vecOvf, w_vecUnf, w_vecConf, w_vecInact;
    logic [NUM_WARPS-1:0] w_byCode [1:6];
    logic                 w_splitDiv;
    logic                 w_errAny;
    logic [2:0]           w_errCode;
    logic [WID_W-1:0]     w_errWid;

    logic                 r_errValid;
    logic [2:0]           r_errCode;
    logic [WID_W-1:0]     r_errWid;
    logic [15:0]          r_errCount;

    assign w_splitDiv = (|bus.split_then_mask) && (|bus.split_else_mask);

    for (genvar g = 0; g < NUM_WARPS; g++) begin : gWarp
        localparam logic [WID_W-1:0] WID        = WID_W'(g);
        localparam logic             RST_ACTIVE = (g == 0);
        localparam mask_t            RST_MASK   = (g == 0) ? mask_t'(1) : mask_t'(0);
        localparam pc_t              RST_PC     = (g == 0) ? STARTUP_PC : pc_t'(0);

        logic                   r_active;
        mask_t                  r_mask;
        pc_t                    r_pc;
        sp_t                    r_sp;
        mask_t                  r_stkMask [IPDOM_DEPTH];
        pc_t                    r_stkPc   [IPDOM_DEPTH];
        logic [IPDOM_DEPTH-1:0] r_stkElse;

        logic                 w_hitJoin, w_hitSplit, w_hitTmc, w_any, w_multi;
        logic [NUM_BR_CH-1:0] w_hitBr;
        logic                 w_free1, w_free2;
        mask_t                w_topMask;
        pc_t                  w_topPc;
        logic                 w_topElse;
        logic                 w_brTake;
        pc_t                  w_brTgt;
        logic                 w_nextActive;
        mask_t                w_nextMask;
        pc_t                  w_nextPc;
        logic                 w_push1, w_push2, w_pop, w_clear;
        logic                 w_ovf, w_unf, w_inact;

        assign w_hitJoin  = bus.join_valid  && (bus.join_wid  == WID);
        assign w_hitSplit = bus.split_valid && (bus.split_wid == WID);
        assign w_hitTmc   = bus.tmc_valid   && (bus.tmc_wid   == WID);
        for (genvar c = 0; c < NUM_BR_CH; c++) begin : gBr
            assign w_hitBr[c] = bus.br_valid[c] && (bus.br_wid[c] == WID);
        end
        assign w_any   = w_hitJoin | w_hitSplit | w_hitTmc | (|w_hitBr);
        assign w_multi = $countones({w_hitJoin, w_hitSplit, w_hitTmc, w_hitBr}) > 1;
        assign w_free1 = r_sp <  sp_t'(IPDOM_DEPTH);
        assign w_free2 = r_sp <= sp_t'(IPDOM_DEPTH - 2);

        always_comb begin
            w_topMask = '0;
            w_topPc   = '0;
            w_topElse = 1'b0;
            for (int e = 0; e < IPDOM_DEPTH; e++) begin
                if (r_sp == sp_t'(e + 1)) begin
                    w_topMask = r_stkMask[e];
                    w_topPc   = r_stkPc[e];
                    w_topElse = r_stkElse[e];
                end
            end
        end

        // Only the lowest-numbered channel aimed at this warp is honoured.
        always_comb begin
            w_brTake = 1'b0;
            w_brTgt  = '0;
            for (int c = NUM_BR_CH - 1; c >= 0; c--) begin
                if (w_hitBr[c]) begin
                    w_brTake = bus.br_taken[c];
                    w_brTgt  = bus.br_target[c];
                end
            end
        end

        always_comb begin
            w_nextActive = r_active;
            w_nextMask   = r_mask;
            w_nextPc     = r_pc;
            w_push1      = 1'b0;
            w_push2      = 1'b0;
            w_pop        = 1'b0;
            w_clear      = 1'b0;
            w_ovf        = 1'b0;
            w_unf        = 1'b0;
            w_inact      = 1'b0;
            if (!r_active) begin
                w_inact = w_any;
                if (bus.wspawn_valid && bus.wspawn_mask[g]) begin
                    w_nextActive = 1'b1;
                    w_nextMask   = mask_t'(1);
                    w_nextPc     = bus.wspawn_pc;
                end
            end else if (w_hitJoin) begin
                if (r_sp == '0) begin
                    w_unf = 1'b1;
                end else begin
                    w_pop      = 1'b1;
                    w_nextMask = w_topMask;
                    if (w_topElse) w_nextPc = w_topPc;
                end
            end else if (w_hitSplit) begin
                if (w_splitDiv) begin
                    if (w_free2) begin
                        w_push2    = 1'b1;
                        w_nextMask = bus.split_then_mask;
                    end else begin
                        w_ovf = 1'b1;
                    end
                end else if (w_free1) begin
                    w_push1 = 1'b1;
                end else begin
                    w_ovf = 1'b1;
                end
            end else if (w_hitTmc) begin
                w_nextMask = bus.tmc_mask;
                if (bus.tmc_mask == '0) begin
                    w_nextActive = 1'b0;
                    w_clear      = 1'b1;
                end
            end else if (w_brTake) begin
                w_nextPc = w_brTgt;
            end
        end

        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_active <= RST_ACTIVE;
                r_mask   <= RST_MASK;
                r_pc     <= RST_PC;
                r_sp     <= '0;
            end else begin
                r_active <= w_nextActive;
                r_mask   <= w_nextMask;
                r_pc     <= w_nextPc;
                if (w_clear)      r_sp <= '0;
                else if (w_push2) r_sp <= r_sp + sp_t'(2);
                else if (w_push1) r_sp <= r_sp + sp_t'(1);
                else if (w_pop)   r_sp <= r_sp - sp_t'(1);
            end
        end

        // The fallthrough entry always lands at the current top; a divergent split adds the else entry above it.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                for (int e = 0; e < IPDOM_DEPTH; e++) begin
                    r_stkMask[e] <= '0;
                    r_stkPc[e]   <= '0;
                end
                r_stkElse <= '0;
            end else begin
                for (int e = 0; e < IPDOM_DEPTH; e++) begin
                    if ((w_push1 || w_push2) && (r_sp == sp_t'(e))) begin
                        r_stkMask[e] <= r_mask;
                        r_stkPc[e]   <= r_pc;
                        r_stkElse[e] <= 1'b0;
                    end else if (w_push2 && (r_sp == sp_t'(e - 1))) begin
                        r_stkMask[e] <= bus.split_else_mask;
                        r_stkPc[e]   <= bus.split_else_pc;
                        r_stkElse[e] <= 1'b1;
                    end
                end
            end
        end

        assign w_vecAct[g]   = bus.check_en && (bus.obs_active_warps[g] != r_active);
        assign w_vecMask[g]  = bus.check_en && r_active && (bus.obs_thread_masks[g] != r_mask);
        assign w_vecOvf[g]   = w_ovf;
        assign w_vecUnf[g]   = w_unf;
        assign w_vecConf[g]  = r_active && w_multi;
        assign w_vecInact[g] = w_inact;

        assign bus.exp_active_warps[g] = r_active;
        assign bus.exp_thread_masks[g] = r_mask;
        assign bus.exp_warp_pcs[g]     = r_pc;
        assign bus.ipdom_depth[g]      = r_sp;
    end

    always_comb begin
        w_byCode[1] = w_vecAct;
        w_byCode[2] = w_vecMask;
        w_byCode[3] = w_vecOvf;
        w_byCode[4] = w_vecUnf;
        w_byCode[5] = w_vecConf;
        w_byCode[6] = w_vecInact;
    end

    // Lowest code wins, then lowest warp carrying that code.
    always_comb begin
        w_errAny  = 1'b0;
        w_errCode = 3'd0;
        w_errWid  = '0;
        for (int k = 6; k >= 1; k--) begin
            if (|w_byCode[k]) begin
                w_errAny  = 1'b1;
                w_errCode = 3'(k);
                for (int w = NUM_WARPS - 1; w >= 0; w--) begin
                    if (w_byCode[k][w]) w_errWid = WID_W'(w);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_errValid <= 1'b0;
            r_errCode  <= 3'd0;
            r_errWid   <= '0;
            r_errCount <= 16'd0;
        end else begin
            r_errValid <= w_errAny;
            r_errCode  <= w_errCode;
            r_errWid   <= w_errWid;
            if (w_errAny && (r_errCount != 16'hFFFF)) r_errCount <= r_errCount + 16'd1;
        end
    end

    assign bus.err_valid = r_errValid;
    assign bus.err_code  = r_errCode;
    assign bus.err_wid   = r_errWid;
    assign bus.err_count = r_errCount;
endmodule

// File: doc/vx_sched_state_mon.md
VX_SCHED_STATE_MON -- requirements
Module: VX_sched_state_mon

Interface
REQ-001 SHALL have parameter NUM_WARPS, default 4, number of warps modelled.
REQ-002 SHALL have parameter NUM_THREADS, default 4, threads per warp.
REQ-003 SHALL have parameter NUM_BR_CH, default 2, parallel branch channels (1..4).
REQ-004 SHALL have parameter IPDOM_DEPTH, default 4, IPDOM entries per warp (even, >=2).
REQ-005 SHALL have parameters PC_BITS, default 30, and STARTUP_PC, default 0.
REQ-006 SHALL have ports, one per line:
- clk  in  1  sole clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- wspawn_valid  in  1;  wspawn_mask  in  NUM_WARPS;  wspawn_pc  in  PC_BITS.
- tmc_valid  in  1;  tmc_wid  in  log2(NUM_WARPS);  tmc_mask  in  NUM_THREADS.
- split_valid  in  1;  split_wid  in  log2(NUM_WARPS);  split_then_mask, split_else_mask  in  NUM_THREADS;  split_else_pc  in  PC_BITS.
- join_valid  in  1;  join_wid  in  log2(NUM_WARPS).
- br_valid, br_taken  in  NUM_BR_CH;  br_wid  in  NUM_BR_CH x log2(NUM_WARPS);  br_target  in  NUM_BR_CH x PC_BITS.
- check_en  in  1  enables comparison against observed state.
- obs_active_warps  in  NUM_WARPS;  obs_thread_masks  in  NUM_WARPS x NUM_THREADS.
- exp_active_warps  out  NUM_WARPS;  exp_thread_masks  out  NUM_WARPS x NUM_THREADS;  exp_warp_pcs  out  NUM_WARPS x PC_BITS.
- ipdom_depth  out  NUM_WARPS x log2(IPDOM_DEPTH+1)  per-warp stack occupancy.
- err_valid  out  1;  err_code  out  3;  err_wid  out  log2(NUM_WARPS);  err_count  out  16.

Function
REQ-007 SHALL update all exp_* and ipdom_depth registers on the clock edge at which the causing event is sampled (visible next cycle).
REQ-008 wspawn: each inactive warp in wspawn_mask SHALL become active, mask = thread 0 only, pc = wspawn_pc; active warps in mask unchanged, no error.
REQ-009 tmc: active warp tmc_wid SHALL take mask = tmc_mask; tmc_mask == 0 SHALL deactivate the warp and clear its IPDOM stack.
REQ-010 divergent split (then and else masks both nonzero) SHALL push {current mask, fallthrough} then {else_mask, else_pc, else}, and set mask = then_mask; needs 2 free entries.
REQ-011 non-divergent split SHALL push one {current mask, fallthrough} entry; mask unchanged.
REQ-012 join SHALL pop top entry: else entry sets mask and pc from entry; fallthrough entry sets mask only.
REQ-013 split without enough free entries SHALL raise IPDOM_OVF (code 3), state unchanged; join on empty stack SHALL raise IPDOM_UNF (code 4), state unchanged.
REQ-014 taken branch on channel c SHALL set pc of br_wid[c] = br_target[c]; not-taken leaves pc unchanged.
REQ-015 any event targeting an inactive warp SHALL be dropped and raise INACTIVE (code 6).
REQ-016 same-warp collisions in one cycle: priority join > split > tmc > branch (lowest channel first); highest-priority event applied, others dropped, CONFLICT (code 5) raised. wspawn never conflicts.
REQ-017 events on distinct warps in one cycle SHALL all apply.
REQ-018 when check_en=1, obs_active_warps != exp_active_warps SHALL raise MISMATCH_ACTIVE (code 1); any active warp with obs mask != exp mask SHALL raise MISMATCH_MASK (code 2). Comparison uses current register values.
REQ-019 err_valid SHALL pulse one cycle after detection with lowest error code detected that cycle and lowest warp id carrying it; err_code 0 when err_valid=0.
REQ-020 err_count SHALL increment once per cycle with err_valid=1, saturating at 16'hFFFF.

Reset
REQ-021 reset low SHALL asynchronously set: warp 0 active, mask thread 0 only, pc = STARTUP_PC; other warps inactive, mask 0, pc 0; all stacks empty; err_valid 0, err_code 0, err_wid 0, err_count 0.
REQ-022 reset asserted mid-operation SHALL discard all stack contents and in-flight events; first event after deassertion is sampled on the first rising edge with reset high.

Verification
REQ-023 reset release, wspawn_mask=4'b1110, pc=0x100 -> next cycle exp_active_warps=4'b1111, warps 1-3 mask 4'b0001, pc 0x100.
REQ-024 warp 0 tmc 4'b1111, split then=4'b0011 else=4'b1100 pc=0x40, join, join -> masks 4'b0011, 4'b1100 (pc 0x40), 4'b1111; depth 2,1,0.
REQ-025 three divergent splits on warp 1 with IPDOM_DEPTH=4 -> third split: err_code 3, err_wid 1, depth stays 4; then 5 joins -> fifth: err_code 4.
REQ-026 tmc and join on warp 2 same cycle -> join applied, err_code 5, err_wid 2; two taken branches on warp 0 -> pc = channel 0 target, code 5.
REQ-027 check_en=1, obs_thread_masks[0] differs by one bit -> err_code 2, err_wid 0, err_count +1; forced 0xFFFF stays 0xFFFF.
REQ-028 reset low for one cycle after two pushes on warp 0 -> depth 0, only warp 0 active, err_count 0.
